// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter: FSM states,
// odd-parity function and the common keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_ACK,
        ST_RELEASE,
        ST_DONE
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 frames carry odd parity: the parity bit makes the 9-bit total odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, FILT_LEN-sample glitch filter and a
// one-cycle strobe on every accepted 1->0 transition.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // The level flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one byte on device clock edges and reports the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_KHZ    = 24000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int INHIBIT_CYC = (CLK_KHZ / 10 > 0) ? CLK_KHZ / 10 : 1;
    localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
    localparam int WD_LIMIT    = CLK_KHZ * TIMEOUT_MS;
    localparam int WD_W        = $clog2(WD_LIMIT + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_LIMIT - 1);

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_wd_expired;

    ps2_state_t       r_state;
    logic [INH_W-1:0] r_inh_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bit_idx;
    logic             r_ack_seen;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_ready;
    logic             r_done;
    logic             r_ack_ok;
    logic             r_err;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_pad   (ps2_clk_i),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filter (
        .clk     (clk),
        .reset   (reset),
        .i_pad   (ps2_dat_i),
        .o_level (w_dat_level),
        .o_fall  ()
    );

    assign w_wd_expired = (r_wd_cnt == WD_LAST);

    // Inhibit unconditionally overrides any device-to-host frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_inh_cnt  <= '0;
            r_wd_cnt   <= '0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_ack_seen <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_ack_ok <= 1'b0;
            r_err    <= 1'b0;
            if (r_state inside {ST_REQ, ST_DATA, ST_ACK, ST_RELEASE}) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && r_ready) begin
                        r_data    <= tx_data;
                        r_parity  <= odd_parity(tx_data);
                        r_ready   <= 1'b0;
                        r_clk_oe  <= 1'b1;
                        r_dat_oe  <= 1'b0;
                        r_inh_cnt <= '0;
                        r_state   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_dat_oe <= 1'b1;
                        r_wd_cnt <= '0;
                        r_state  <= ST_REQ;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end

                ST_REQ: begin
                    r_clk_oe  <= 1'b0;
                    r_bit_idx <= '0;
                    r_state   <= ST_DATA;
                end

                // Edges 1-8 carry d0..d7, edge 9 parity, edge 10 the released stop bit.
                ST_DATA: begin
                    if (w_wd_expired) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_clk_fall) begin
                        if (r_bit_idx < 4'd8) begin
                            r_dat_oe <= ~r_data[r_bit_idx[2:0]];
                        end else if (r_bit_idx == 4'd8) begin
                            r_dat_oe <= ~r_parity;
                        end else begin
                            r_dat_oe <= 1'b0;
                            r_state  <= ST_ACK;
                        end
                        r_bit_idx <= r_bit_idx + 4'd1;
                    end
                end

                ST_ACK: begin
                    if (w_wd_expired) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_clk_fall) begin
                        r_ack_seen <= ~w_dat_level;
                        r_state    <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (w_wd_expired) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (w_clk_level && w_dat_level) begin
                        r_done   <= 1'b1;
                        r_ack_ok <= r_ack_seen;
                        r_state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_ready  <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_dat_oe  = r_dat_oe;
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a simple keyboard model,
// frame and result scoreboards checked as transfers complete.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int CLK_KHZ     = 1000;
    localparam int FILT_LEN    = 8;
    localparam int TIMEOUT_MS  = 1;
    localparam int HALF        = 20;
    localparam int INHIBIT_CYC = 100;
    localparam int WD_CYC      = 1000;

    typedef struct packed {
        logic ack;
        logic err;
    } result_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;
    logic       devClkLow = 1'b0;
    logic       devDatLow = 1'b0;
    logic       ps2ClkLine;
    logic       ps2DatLine;

    logic [9:0] frameQ[$];
    result_t    resultQ[$];
    int         checks = 0;
    int         failures = 0;

    assign ps2ClkLine = ~(ps2_clk_oe | devClkLow);
    assign ps2DatLine = ~(ps2_dat_oe | devDatLow);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_KHZ    (CLK_KHZ),
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2ClkLine),
        .ps2_dat_i   (ps2DatLine),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .done        (done),
        .ack_ok      (ack_ok),
        .err_timeout (err_timeout)
    );

    task automatic applyStimulus(input logic [7:0] data);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic waitForDone(input int budget, output int cycles, output bit seen,
                               output bit leak, output logic a, output logic e,
                               output logic co, output logic dO);
        cycles = 0;
        seen = 1'b0;
        leak = 1'b0;
        a = 1'bx; e = 1'bx; co = 1'bx; dO = 1'bx;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) begin
                seen = 1'b1;
                a = ack_ok; e = err_timeout; co = ps2_clk_oe; dO = ps2_dat_oe;
            end else if (ack_ok !== 1'b0 || err_timeout !== 1'b0) begin
                leak = 1'b1;
            end
        end
    endtask

    // Keyboard model: clocks the frame, samples host data on each rising edge.
    task automatic deviceRun(input bit doAck, input int nEdges, input bit glitch);
        logic [9:0] got;
        logic [9:0] exp;
        int t;
        got = '0;
        t = 0;
        while (!(ps2ClkLine === 1'b1 && ps2DatLine === 1'b0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 3000) begin
            failures++;
            $display("[TB] FAIL dev_start: got clk=%b dat=%b, need clk=1 dat=0", ps2ClkLine, ps2DatLine);
            return;
        end
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= nEdges && e <= 10; e++) begin
            devClkLow = 1'b1;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
            got[e-1] = ps2DatLine;
            repeat (HALF) @(negedge clk);
            if (glitch && e == 3) begin
                devClkLow = 1'b1;
                repeat (3) @(negedge clk);
                devClkLow = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        if (nEdges >= 10) begin
            exp = frameQ.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL frame: got %b, need %b", got, exp);
            end
        end
        if (nEdges >= 11) begin
            devDatLow = doAck;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b1;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
            repeat (HALF) @(negedge clk);
            devDatLow = 1'b0;
        end
    endtask

    task automatic runTransfer(input logic [7:0] d, input bit doAck, output bit seen,
                               output bit leak, output logic a, output logic e);
        int cyc;
        logic co, dO;
        frameQ.push_back({1'b1, ~^d, d});
        resultQ.push_back('{ack: doAck, err: 1'b0});
        applyStimulus(d);
        fork
            deviceRun(doAck, 11, 1'b0);
            waitForDone(2000, cyc, seen, leak, a, e, co, dO);
        join
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_ready !== 1'b1)    begin failures++; $display("[TB] FAIL rst_ready: got %b, need 1", tx_ready); end
        checks++; if (ps2_clk_oe !== 1'b0)  begin failures++; $display("[TB] FAIL rst_clk_oe: got %b, need 0", ps2_clk_oe); end
        checks++; if (ps2_dat_oe !== 1'b0)  begin failures++; $display("[TB] FAIL rst_dat_oe: got %b, need 0", ps2_dat_oe); end
        checks++; if (done !== 1'b0)        begin failures++; $display("[TB] FAIL rst_done: got %b, need 0", done); end
        checks++; if (ack_ok !== 1'b0)      begin failures++; $display("[TB] FAIL rst_ack: got %b, need 0", ack_ok); end
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("[TB] FAIL rst_err: got %b, need 0", err_timeout); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_send_ed;
        logic [7:0] d;
        int t, cyc;
        bit seen, leak;
        logic a, e, co, dO;
        result_t r;
        d = CMD_SET_LEDS;
        frameQ.push_back({1'b1, ~^d, d});
        resultQ.push_back('{ack: 1'b1, err: 1'b0});
        applyStimulus(d);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL ready_drop: got %b, need 0", tx_ready); end
        checks++;
        if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) begin
            failures++; $display("[TB] FAIL inhibit_lines: got clk_oe=%b dat_oe=%b, need 1 0", ps2_clk_oe, ps2_dat_oe);
        end
        t = 0;
        while (ps2_dat_oe !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++; if (t !== INHIBIT_CYC) begin failures++; $display("[TB] FAIL inhibit_len: got %0d, need %0d", t, INHIBIT_CYC); end
        checks++; if (ps2_clk_oe !== 1'b1) begin failures++; $display("[TB] FAIL req_clk_oe: got %b, need 1", ps2_clk_oe); end
        fork
            deviceRun(1'b1, 11, 1'b0);
            waitForDone(2000, cyc, seen, leak, a, e, co, dO);
        join
        r = resultQ.pop_front();
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ed_done: got %b, need 1", seen); end
        checks++; if (a !== r.ack)   begin failures++; $display("[TB] FAIL ed_ack: got %b, need %b", a, r.ack); end
        checks++; if (e !== r.err)   begin failures++; $display("[TB] FAIL ed_err: got %b, need %b", e, r.err); end
        checks++; if (leak !== 1'b0) begin failures++; $display("[TB] FAIL ed_flag_leak: got %b, need 0", leak); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] cmds [2];
        bit seen, leak;
        logic a, e;
        result_t r;
        cmds[0] = 8'h01;
        cmds[1] = CMD_RESET;
        for (int i = 0; i < 2; i++) begin
            runTransfer(cmds[i], 1'b1, seen, leak, a, e);
            r = resultQ.pop_front();
            checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done[%0d]: got %b, need 1", i, seen); end
            checks++; if (a !== r.ack)   begin failures++; $display("[TB] FAIL b2b_ack[%0d]: got %b, need %b", i, a, r.ack); end
            checks++; if (e !== r.err)   begin failures++; $display("[TB] FAIL b2b_err[%0d]: got %b, need %b", i, e, r.err); end
        end
    endtask

    task automatic test_nack;
        bit seen, leak;
        logic a, e;
        result_t r;
        runTransfer(CMD_ENABLE, 1'b0, seen, leak, a, e);
        r = resultQ.pop_front();
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL nack_done: got %b, need 1", seen); end
        checks++; if (a !== r.ack)   begin failures++; $display("[TB] FAIL nack_ack: got %b, need %b", a, r.ack); end
        checks++; if (e !== r.err)   begin failures++; $display("[TB] FAIL nack_err: got %b, need %b", e, r.err); end
    endtask

    task automatic test_timeout;
        int t, cyc;
        bit seen, leak;
        logic a, e, co, dO;
        result_t r;
        resultQ.push_back('{ack: 1'b0, err: 1'b1});
        applyStimulus(CMD_RESET);
        t = 0;
        while (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++; if (t >= 500) begin failures++; $display("[TB] FAIL to_req: got no REQ in %0d cycles, need REQ", t); end
        waitForDone(WD_CYC + 100, cyc, seen, leak, a, e, co, dO);
        r = resultQ.pop_front();
        checks++; if (seen !== 1'b1)  begin failures++; $display("[TB] FAIL to_done: got %b, need 1", seen); end
        checks++; if (cyc > WD_CYC)   begin failures++; $display("[TB] FAIL to_latency: got %0d, need <= %0d", cyc, WD_CYC); end
        checks++; if (e !== r.err)    begin failures++; $display("[TB] FAIL to_err: got %b, need %b", e, r.err); end
        checks++; if (a !== r.ack)    begin failures++; $display("[TB] FAIL to_ack: got %b, need %b", a, r.ack); end
        checks++;
        if (co !== 1'b0 || dO !== 1'b0) begin
            failures++; $display("[TB] FAIL to_lines: got clk_oe=%b dat_oe=%b, need 0 0", co, dO);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit seen, leak;
        logic a, e, co, dO;
        applyStimulus(CMD_SET_LEDS);
        deviceRun(1'b1, 5, 1'b0);
        checks++; if (ps2_dat_oe !== 1'b1) begin failures++; $display("[TB] FAIL mid_d4: got %b, need 1", ps2_dat_oe); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_release: got clk_oe=%b dat_oe=%b, need 0 0", ps2_clk_oe, ps2_dat_oe);
        end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready: got %b, need 1", tx_ready); end
        reset = 1'b0;
        waitForDone(300, cyc, seen, leak, a, e, co, dO);
        checks++; if (seen !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_done: got %b, need 0", seen); end
    endtask

    task automatic test_ignore_valid;
        logic [7:0] d;
        int cyc;
        bit seen, leak, busy;
        logic a, e, co, dO, rdyAtPulse;
        result_t r;
        d = CMD_ENABLE;
        frameQ.push_back({1'b1, ~^d, d});
        resultQ.push_back('{ack: 1'b1, err: 1'b0});
        applyStimulus(d);
        rdyAtPulse = 1'bx;
        fork
            deviceRun(1'b1, 11, 1'b1);
            waitForDone(2500, cyc, seen, leak, a, e, co, dO);
            begin
                repeat (200) @(negedge clk);
                rdyAtPulse = tx_ready;
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        r = resultQ.pop_front();
        checks++; if (rdyAtPulse !== 1'b0) begin failures++; $display("[TB] FAIL ign_ready: got %b, need 0", rdyAtPulse); end
        checks++; if (seen !== 1'b1) begin failures++; $display("[TB] FAIL ign_done: got %b, need 1", seen); end
        checks++; if (a !== r.ack)   begin failures++; $display("[TB] FAIL ign_ack: got %b, need %b", a, r.ack); end
        checks++; if (e !== r.err)   begin failures++; $display("[TB] FAIL ign_err: got %b, need %b", e, r.err); end
        busy = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b0) busy = 1'b1;
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ign_no_queue: got %b, need 0", busy); end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_ignore_valid();
        checks++;
        if (frameQ.size() != 0 || resultQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d left, need 0/0", frameQ.size(), resultQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, need finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_KHZ, default 24000: system clock frequency in kHz; all timing counts derive from it.
REQ-002 Parameter FILT_LEN, default 8: consecutive equal samples needed to accept a new PS/2 line level.
REQ-003 Parameter TIMEOUT_MS, default 20: watchdog limit from request-to-send to completion.
REQ-004 clk  in  1  system clock; the block uses one clock.
REQ-005 reset  in  1  reset; synchronous and active-high.
REQ-006 tx_data  in  8  command byte to send to the keyboard (e.g. 0xED, 0xFF).
REQ-007 tx_valid  in  1  request; accepted only when tx_ready=1.
REQ-008 tx_ready  out  1  high only in IDLE.
REQ-009 ps2_clk_i  in  1  raw PS/2 clock pad level; asynchronous.
REQ-010 ps2_dat_i  in  1  raw PS/2 data pad level; asynchronous.
REQ-011 ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
REQ-012 ps2_dat_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-013 done  out  1  one-cycle pulse at end of every accepted transfer.
REQ-014 ack_ok  out  1  valid with done; 1 = device ACK seen.
REQ-015 err_timeout  out  1  valid with done; 1 = watchdog expired.

Function
REQ-016 Both PS/2 inputs SHALL pass a 2-FF synchronizer, then a FILT_LEN-sample filter; a clock falling edge is a filtered 1->0 transition.
REQ-017 On tx_valid&&tx_ready the block SHALL latch tx_data and compute odd parity = ~^tx_data; tx_ready drops the next cycle.
REQ-018 tx_valid while tx_ready=0 SHALL be ignored, with no queueing.
REQ-019 States: IDLE, INHIBIT, REQ, DATA, ACK, RELEASE, DONE.
REQ-020 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for CLK_KHZ/10 cycles (100 us), then REQ.
REQ-021 REQ: ps2_dat_oe=1 (start bit); ps2_clk_oe=1 for one further cycle, then 0; the watchdog starts; go to DATA.
REQ-022 DATA: on each filtered falling edge the next bit SHALL be presented (ps2_dat_oe = ~bit): edges 1-8 give d0..d7 LSB first, edge 9 gives parity, and edge 10 gives the stop bit (release); then go to ACK.
REQ-023 ACK: on the next falling edge, sample filtered data; 0 means ack_ok=1, 1 means ack_ok=0; go to RELEASE.
REQ-024 RELEASE: wait until filtered clock and data are both 1, then DONE.
REQ-025 DONE: pulse done for one cycle with ack_ok/err_timeout held that cycle, then IDLE.
REQ-026 Watchdog counter SHALL be sized for CLK_KHZ*TIMEOUT_MS; if it expires in DATA, ACK or RELEASE, both oe SHALL be 0 next cycle, then DONE with err_timeout=1 and ack_ok=0.
REQ-027 Device-to-host traffic in progress at acceptance SHALL be overridden by INHIBIT, per the PS/2 host-priority rule.
REQ-028 ack_ok and err_timeout SHALL be 0 outside the done cycle.

Reset
REQ-029 While reset=1, on the next clk edge: state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, done=0, ack_ok=0, err_timeout=0, counters=0, filters preset to 1.
REQ-030 Reset mid-transfer SHALL abort without a done pulse and release both lines within one cycle.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, the odd-parity function, and the command constants (0xED set-LEDs, 0xFF reset, 0xF4 enable).
REQ-032 One sub-module, ps2_line_filter (synchronizer, glitch filter, falling-edge strobe), SHALL be instantiated twice, once per line.

Verification
REQ-033 Send 0xED to an ACKing device model -> bits 1,0,1,1,0,1,1,1, parity 1, stop released; done with ack_ok=1, err_timeout=0.
REQ-034 Send 0x01, then 0xFF -> parity 0, then parity 1; both ack_ok=1.
REQ-035 Device leaves data high on the 11th edge -> done with ack_ok=0, err_timeout=0.
REQ-036 Device never clocks (CLK_KHZ=1000, TIMEOUT_MS=1) -> done with err_timeout=1 at most 1000 cycles after REQ; both oe=0.
REQ-037 Reset during d4 -> both oe=0 and tx_ready=1 next cycle, and no done pulse; a clock glitch shorter than FILT_LEN mid-transfer -> no bit advance.
REQ-038 Pulse tx_valid (0x55) during DATA -> ignored; the current byte completes unchanged.
